// File: rtl/mac_accum_scheduler.sv
// -----------------------------------------------------------------------------
// mac_accum_scheduler
//
// Purpose:
//    Computes a signed dot product sum(a[i] * b[i]) over a job of len pairs by
//    driving an external pipelined muladd unit (dout = din0*din1 + din2, LAT
//    stages deep, 38-bit wrapping result). Because the muladd result for one
//    op is only available LAT cycles after issue, the accumulation is spread
//    round-robin over LAT independent partial sums (lanes). Every issued op
//    is tagged with its lane; when the tag falls out of the tag shift register
//    the muladd output is written back into that lane. Once the pipeline has
//    drained, the lanes are sign-extended and added into a 40-bit result that
//    is offered on a valid/ready output stream.
//
// Parameters:
//    LAT    - pipeline depth of the external muladd (its NUM_STAGE)
//    LEN_W  - width of the job length input
//
// Ports:
//    ap_clk      in   clock, all state changes on its rising edge
//    ap_rst_n    in   asynchronous active-low reset
//    start       in   one-cycle job request, only honoured in IDLE
//    len         in   number of (a,b) pairs in the job, latched on start
//    busy        out  high whenever the scheduler is not IDLE
//    done        out  one-cycle pulse on the result handshake
//    in_valid    in   operand pair valid
//    in_ready    out  scheduler can accept an operand pair
//    in_a        in   24-bit signed operand
//    in_b        in   4-bit unsigned operand
//    mac_ce      out  clock enable of the external muladd
//    mac_din0    out  muladd multiplicand (a)
//    mac_din1    out  muladd multiplier (b)
//    mac_din2    out  muladd addend (running partial sum of the lane)
//    mac_dout    in   muladd result, LAT cycles after issue
//    out_valid   out  result valid
//    out_ready   in   result consumer ready
//    out_data    out  40-bit signed dot product
// -----------------------------------------------------------------------------
module mac_accum_scheduler #(
   parameter int LAT   = 4,
   parameter int LEN_W = 16
) (
   input  logic                    ap_clk,
   input  logic                    ap_rst_n,
   input  logic                    start,
   input  logic [LEN_W-1:0]        len,
   output logic                    busy,
   output logic                    done,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [23:0]      in_a,
   input  logic [3:0]              in_b,
   output logic                    mac_ce,
   output logic [23:0]             mac_din0,
   output logic [3:0]              mac_din1,
   output logic [37:0]             mac_din2,
   input  logic [37:0]             mac_dout,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [39:0]      out_data
);

   localparam int LANE_W = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCUM,
      S_DRAIN,
      S_REDUCE,
      S_OUT
   } state_t;

   state_t               state;
   state_t               state_next;

   logic [LEN_W-1:0]     len_q;
   logic [LEN_W-1:0]     issue_cnt;
   logic [LANE_W-1:0]    lane_ptr;

   logic [37:0]          psum [LAT];

   logic [LAT-1:0]       tag_valid;
   logic [LANE_W-1:0]    tag_lane [LAT];

   logic                 issue;
   logic                 exit_valid;
   logic [LANE_W-1:0]    exit_lane;
   logic                 forward;
   logic                 start_job;
   logic signed [39:0]   lane_sum;

   // A pair is consumed only while the job still has pairs outstanding and
   // the scheduler is in ACCUM; every other cycle with the muladd enabled is a
   // bubble whose tag is invalid, so its result is simply never written back.
   always_comb begin
      in_ready   = (state == S_ACCUM) && (issue_cnt < len_q);
      issue      = in_ready && in_valid;
      mac_ce     = (state == S_ACCUM) || (state == S_DRAIN);
      start_job  = (state == S_IDLE) && start;
   end

   // The tag leaving the last stage lines up with the muladd result for the
   // op that created it. If the lane being issued right now is the same lane
   // whose result is arriving, the partial sum register is one cycle stale,
   // so the fresh muladd output is forwarded straight into din2 instead.
   always_comb begin
      exit_valid = mac_ce && tag_valid[LAT-1];
      exit_lane  = tag_lane[LAT-1];
      forward    = exit_valid && (exit_lane == lane_ptr);
      mac_din0   = '0;
      mac_din1   = '0;
      mac_din2   = '0;
      if (issue) begin
         mac_din0 = in_a;
         mac_din1 = in_b;
         mac_din2 = forward ? mac_dout : psum[lane_ptr];
      end
   end

   // State register for the job sequencing FSM.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake outputs. ACCUM leaves one cycle after the last
   // pair was taken, DRAIN waits until no valid tag is left in flight, REDUCE
   // is the single cycle in which the lanes are folded into out_data, and OUT
   // holds the result until the consumer accepts it.
   always_comb begin
      state_next = state;
      busy       = (state != S_IDLE);
      out_valid  = 1'b0;
      done       = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               state_next = (len == '0) ? S_DRAIN : S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (issue_cnt >= len_q) begin
               state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (tag_valid == '0) begin
               state_next = S_REDUCE;
            end
         end
         S_REDUCE: begin
            state_next = S_OUT;
         end
         S_OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               done       = 1'b1;
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Job bookkeeping: length is captured on an accepted start, and the issue
   // count and lane pointer restart from zero. The lane pointer wraps at LAT
   // so it always equals issue count mod LAT without needing a divider.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         len_q     <= '0;
         issue_cnt <= '0;
         lane_ptr  <= '0;
      end else if (start_job) begin
         len_q     <= len;
         issue_cnt <= '0;
         lane_ptr  <= '0;
      end else if (issue) begin
         issue_cnt <= issue_cnt + LEN_W'(1);
         lane_ptr  <= (lane_ptr == LAST_LANE) ? '0 : lane_ptr + LANE_W'(1);
      end
   end

   // Tag shift register mirrors the muladd pipeline: it only moves when the
   // muladd is clock-enabled, so tag and data stay aligned stage for stage.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         tag_valid <= '0;
         for (int i = 0; i < LAT; i++) begin
            tag_lane[i] <= '0;
         end
      end else if (mac_ce) begin
         for (int i = LAT - 1; i > 0; i--) begin
            tag_valid[i] <= tag_valid[i-1];
            tag_lane[i]  <= tag_lane[i-1];
         end
         tag_valid[0] <= issue;
         tag_lane[0]  <= lane_ptr;
      end
   end

   // Partial sums are cleared when a job starts and otherwise only updated by
   // write-back of a valid exiting tag. The muladd already wraps at 38 bits,
   // so each lane inherits that modulo behaviour for free.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         for (int i = 0; i < LAT; i++) begin
            psum[i] <= '0;
         end
      end else if (start_job) begin
         for (int i = 0; i < LAT; i++) begin
            psum[i] <= '0;
         end
      end else if (exit_valid) begin
         psum[exit_lane] <= mac_dout;
      end
   end

   // Fold all lanes into one 40-bit value; each lane is sign-extended first
   // so negative partial sums reduce correctly.
   always_comb begin
      lane_sum = '0;
      for (int i = 0; i < LAT; i++) begin
         lane_sum = lane_sum + {{2{psum[i][37]}}, psum[i]};
      end
   end

   // The result is captured once in REDUCE and then left untouched, which
   // keeps out_data stable for as long as the consumer stalls in OUT.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         out_data <= '0;
      end else if (state == S_REDUCE) begin
         out_data <= lane_sum;
      end
   end

endmodule

// File: doc/mac_accum_scheduler.md
MAC_ACCUM_SCHEDULER -- requirements
Module: mac_accum_scheduler

Interface
REQ-001 SHALL have parameter LAT, default 4: pipeline depth of the external 24s x 4ns + 38s muladd unit; set equal to that unit's NUM_STAGE.
REQ-002 SHALL have parameter LEN_W, default 16: width of the vector-length input.
REQ-003 SHALL have port ap_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port ap_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: single-cycle job request; sampled only in IDLE.
REQ-006 SHALL have port len, input, LEN_W bits: number of (a,b) pairs in the job; latched on start.
REQ-007 SHALL have ports busy and done, output, 1 bit each: busy is high in every state except IDLE; done is a 1-cycle pulse on result handshake.
REQ-008 SHALL have ports in_valid (input, 1 bit), in_ready (output, 1 bit), in_a (input, 24 bits, signed) and in_b (input, 4 bits, unsigned): the operand stream.
REQ-009 SHALL have ports mac_ce (output, 1 bit), mac_din0 (output, 24 bits), mac_din1 (output, 4 bits), mac_din2 (output, 38 bits) and mac_dout (input, 38 bits): these drive the external muladd, where dout = din0*din1 + din2.
REQ-010 SHALL have ports out_valid (output, 1 bit), out_ready (input, 1 bit) and out_data (output, 40 bits, signed): the result stream.

Function
REQ-011 SHALL implement the FSM IDLE -> ACCUM -> DRAIN -> REDUCE -> OUT -> IDLE, plus the transition IDLE -> DRAIN when start arrives with len==0.
REQ-012 In IDLE, start SHALL latch len, clear the issue count, clear the lane pointer and clear the LAT partial-sum registers psum[0..LAT-1] to 0; start outside IDLE SHALL be ignored.
REQ-013 In ACCUM, in_ready SHALL be 1 while issue count < len, and 0 in every other state.
REQ-014 Each in_valid&&in_ready cycle SHALL issue one op that cycle: din0=in_a, din1=in_b, din2 as per REQ-016, tagged with lane = issue count mod LAT. Issue count and lane pointer then advance.
REQ-015 Cycles with no accepted pair SHALL issue a bubble: din0=0, din1=0, din2=0, tag invalid.
REQ-016 Tag shift register (valid, lane), LAT deep, advances when mac_ce=1.
  - Tag exiting with valid and lane L: write psum[L] <= mac_dout.
  - If the issuing lane equals L in that same cycle, din2 SHALL be mac_dout (forwarding); otherwise din2 SHALL be psum[lane].
REQ-017 mac_ce SHALL be 1 in ACCUM and DRAIN and 0 otherwise; a result issued at cycle t is present on mac_dout at t+LAT.
REQ-018 ACCUM SHALL go to DRAIN in the cycle after issue count reaches len. DRAIN SHALL go to REDUCE once the tag register holds no valid entry.
REQ-019 REDUCE (1 cycle) SHALL register out_data = sum of the sign-extended psum lanes, computed at 40 bits.
REQ-020 OUT SHALL hold out_valid=1 with out_data stable until out_ready=1. In the handshake cycle it SHALL pulse done=1, and the next state is IDLE.
REQ-021 Arithmetic SHALL wrap: each lane is modulo 2^38 (muladd behaviour). Results are exact for len <= 4096.

Reset
REQ-022 ap_rst_n=0 SHALL, asynchronously:
  - set the FSM to IDLE;
  - clear psum, the tag register, the counters and out_data to 0;
  - drive in_ready=0, out_valid=0, done=0, busy=0, mac_ce=0 and all mac_din* to 0.
REQ-023 Reset asserted mid-job SHALL discard all in-flight work; the next job SHALL show no residue from it.

Verification
REQ-024 len=0, start -> no in_ready; out_valid with out_data=0; done on handshake.
REQ-025 len=8, back-to-back a=1000, b=3, out_ready=1 -> out_data=24000; forwarding path exercised on every issue from the 5th onward.
REQ-026 len=5, a=-8388608, b=15 -> out_data=-629145600.
REQ-027 len=6, in_valid toggling every other cycle, a=1..6, b=2 -> out_data=42; bubbles contribute nothing.
REQ-028 len=4, a=5, b=1, out_ready held 0 for 10 cycles -> out_valid=1 and out_data=20 held stable; done only in the handshake cycle.
REQ-029 ap_rst_n pulsed low during ACCUM of a len=8 job, then len=4, a=7, b=1 -> out_data=28.
